// File: rtl/ramb_dp_param.sv
// ramb_dp_param
//   Simple-dual-port synchronous block RAM used as the data/instruction memory.
//   Port A reads and writes with byte-lane enables. Port B is read-only.
//   The write mode is selectable, an optional output register can be added,
//   and a sequential engine can zero the whole array.
//
// Ports
//   clka     in   1       clock, everything on the rising edge
//   rsta_n   in   1       asynchronous active-low reset (the array itself is not reset)
//   ena      in   1       port A enable
//   wea      in   NB      port A byte-lane write enables (bit i -> dina[8i+7:8i])
//   addra    in   ADDR_W  port A address
//   dina     in   DATA_W  port A write data
//   douta    out  DATA_W  port A read data
//   enb      in   1       port B read enable
//   addrb    in   ADDR_W  port B address
//   doutb    out  DATA_W  port B read data
//   clr_req  in   1       one-cycle request to zero the array
//   busy     out  1       clear in progress; port accesses are ignored
//
// Parameters
//   WRITE_MODE  0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE (douta during a port A write)
//   OUT_REG     1 adds a second output stage (read latency 2 instead of 1)
//   CLEAR_ON_RST 1 runs the clear engine right after reset release

module ramb_dp_param #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 6,
    parameter int WRITE_MODE   = 0,
    parameter int OUT_REG      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  ena,
    input  logic [DATA_W/8-1:0]   wea,
    input  logic [ADDR_W-1:0]     addra,
    input  logic [DATA_W-1:0]     dina,
    output logic [DATA_W-1:0]     douta,
    input  logic                  enb,
    input  logic [ADDR_W-1:0]     addrb,
    output logic [DATA_W-1:0]     doutb,
    input  logic                  clr_req,
    output logic                  busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t              state_reg;
    logic                busy_reg;
    logic [ADDR_W-1:0]   cnt_reg;
    logic                clearing;

    logic [NB-1:0]       lane_we;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;

    logic [DATA_W-1:0]   a_stage1;
    logic [DATA_W-1:0]   b_stage1;
    logic [DATA_W-1:0]   a_final;
    logic [DATA_W-1:0]   b_final;

    assign clearing = (state_reg == ST_CLEAR);

    // ------------------------------------------------------------------
    // Clear engine. busy mirrors the CLEAR state as a registered output;
    // the last clear edge (the one writing DEPTH-1) returns to IDLE, so
    // busy stays high for exactly DEPTH edges.
    // ------------------------------------------------------------------
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_reg <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            busy_reg  <= (CLEAR_ON_RST != 0);
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_reg <= ST_CLEAR;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_reg == {ADDR_W{1'b1}}) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Write port: the clear engine takes over the array while clearing.
    always_comb begin
        lane_we = '0;
        wr_addr = addra;
        wr_data = dina;
        if (clearing) begin
            lane_we = '1;
            wr_addr = cnt_reg;
            wr_data = '0;
        end else if (ena) begin
            lane_we = wea;
        end
    end

    // ------------------------------------------------------------------
    // One byte-wide RAM per lane. Splitting by lane keeps the byte-write
    // template simple and lets WRITE_FIRST merge per lane: written lanes
    // return the new byte, untouched lanes return the stored byte.
    // Port B reads the pre-write contents on a same-address collision
    // because the array update is non-blocking.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] mem [0:DEPTH-1];
        logic [7:0] a_byte_reg;
        logic [7:0] b_byte_reg;

        always_ff @(posedge clka) begin
            if (lane_we[gi]) begin
                mem[wr_addr] <= wr_data[8*gi +: 8];
            end
        end

        always_ff @(posedge clka or negedge rsta_n) begin
            if (!rsta_n) begin
                a_byte_reg <= '0;
                b_byte_reg <= '0;
            end else if (clearing) begin
                a_byte_reg <= '0;
                b_byte_reg <= '0;
            end else begin
                if (ena && (wea == '0 || WRITE_MODE == 0)) begin
                    a_byte_reg <= mem[addra];
                end else if (ena && WRITE_MODE == 1) begin
                    a_byte_reg <= wea[gi] ? dina[8*gi +: 8] : mem[addra];
                end
                // NO_CHANGE write, or ena=0: hold
                if (enb) begin
                    b_byte_reg <= mem[addrb];
                end
            end
        end

        assign a_stage1[8*gi +: 8] = a_byte_reg;
        assign b_stage1[8*gi +: 8] = b_byte_reg;
    end

    // Optional second output stage: reloads from stage 1 every cycle.
    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] a_stage2_reg;
        logic [DATA_W-1:0] b_stage2_reg;

        always_ff @(posedge clka or negedge rsta_n) begin
            if (!rsta_n) begin
                a_stage2_reg <= '0;
                b_stage2_reg <= '0;
            end else if (clearing) begin
                a_stage2_reg <= '0;
                b_stage2_reg <= '0;
            end else begin
                a_stage2_reg <= a_stage1;
                b_stage2_reg <= b_stage1;
            end
        end

        assign a_final = a_stage2_reg;
        assign b_final = b_stage2_reg;
    end else begin : g_no_oreg
        assign a_final = a_stage1;
        assign b_final = b_stage1;
    end

    // The cycle that accepts clr_req still performs its access, so the
    // outputs are masked as soon as busy rises rather than one edge later.
    assign douta = busy_reg ? '0 : a_final;
    assign doutb = busy_reg ? '0 : b_final;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_ramb_dp_param.sv
module tb_ramb_dp_param;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  wea;
    logic [5:0]  addra;
    logic [31:0] dina;
    logic        enb;
    logic [5:0]  addrb;
    logic        clr_req;

    logic [31:0] douta_rf, doutb_rf, douta_wf, doutb_wf;
    logic [31:0] douta_nc, doutb_nc, douta_or, doutb_or;
    logic        busy_rf, busy_wf, busy_nc, busy_or;

    int n_assert = 0;
    int n_fail   = 0;
    int edges;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ramb_dp_param #(.WRITE_MODE(0), .OUT_REG(0)) u_rf (
        .clka(clk), .rsta_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_rf), .enb(enb), .addrb(addrb), .doutb(doutb_rf),
        .clr_req(clr_req), .busy(busy_rf)
    );
    ramb_dp_param #(.WRITE_MODE(1), .OUT_REG(0)) u_wf (
        .clka(clk), .rsta_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_wf), .enb(enb), .addrb(addrb), .doutb(doutb_wf),
        .clr_req(clr_req), .busy(busy_wf)
    );
    ramb_dp_param #(.WRITE_MODE(2), .OUT_REG(0)) u_nc (
        .clka(clk), .rsta_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_nc), .enb(enb), .addrb(addrb), .doutb(doutb_nc),
        .clr_req(clr_req), .busy(busy_nc)
    );
    ramb_dp_param #(.WRITE_MODE(0), .OUT_REG(1)) u_or (
        .clka(clk), .rsta_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_or), .enb(enb), .addrb(addrb), .doutb(doutb_or),
        .clr_req(clr_req), .busy(busy_or)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a_en, input logic [3:0] we, input logic [5:0] aa,
                         input logic [31:0] d, input logic b_en, input logic [5:0] ab);
        ena   = a_en;
        wea   = we;
        addra = aa;
        dina  = d;
        enb   = b_en;
        addrb = ab;
    endtask

    // Counts edges until busy drops; a clr_req pulse is injected at edge 10.
    task automatic wait_clear(input string tag);
        edges = 0;
        for (int i = 1; i <= 200; i++) begin
            clr_req = (i == 10);
            step();
            if (!busy_rf) begin
                edges = i;
                break;
            end
        end
        clr_req = 1'b0;
        chk(tag, edges, 64);
    endtask

    initial begin
        rst_n   = 1'b0;
        clr_req = 1'b0;
        drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0);
        step();
        step();

        // Reset state
        chk("rst_douta_rf", douta_rf, 32'h0);
        chk("rst_doutb_rf", doutb_rf, 32'h0);
        chk("rst_douta_or", douta_or, 32'h0);
        chk("rst_busy_rf", {31'b0, busy_rf}, 32'h1);
        chk("rst_busy_or", {31'b0, busy_or}, 32'h1);

        // T1: power-on clear lasts exactly 64 edges, array reads back zero
        rst_n = 1'b1;
        wait_clear("t1_busy_edges");
        chk("t1_busy_wf", {31'b0, busy_wf}, 32'h0);
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 4'h0, 6'(i), 32'h0, 1'b1, 6'(63 - i));
            step();
            chk($sformatf("t1_a%0d", i), douta_rf, 32'h0);
            chk($sformatf("t1_b%0d", 63 - i), doutb_rf, 32'h0);
        end
        step();
        chk("t1_or_a", douta_or, 32'h0);

        // T2: READ_FIRST returns old word during write, new word on next read
        drive(1'b1, 4'hF, 6'd1, 32'h0000_0003, 1'b0, 6'd0);
        step();
        chk("t2_rf_wr", douta_rf, 32'h0);
        chk("t2_wf_wr", douta_wf, 32'h0000_0003);
        chk("t2_nc_wr", douta_nc, 32'h0);
        drive(1'b1, 4'h0, 6'd1, 32'h0, 1'b0, 6'd0);
        step();
        chk("t2_rf_rd", douta_rf, 32'h0000_0003);
        chk("t2_nc_rd", douta_nc, 32'h0000_0003);

        // T3: byte-lane partial write
        drive(1'b1, 4'hF, 6'd1, 32'h0000_0607, 1'b0, 6'd0);
        step();
        chk("t3_rf_wr1", douta_rf, 32'h0000_0003);
        chk("t3_wf_wr1", douta_wf, 32'h0000_0607);
        drive(1'b1, 4'b0101, 6'd1, 32'hFFFF_FFFF, 1'b0, 6'd0);
        step();
        chk("t3_rf_wr2", douta_rf, 32'h0000_0607);
        chk("t3_wf_wr2", douta_wf, 32'h00FF_06FF);
        drive(1'b1, 4'h0, 6'd1, 32'h0, 1'b1, 6'd1);
        step();
        chk("t3_rf_rd", douta_rf, 32'h00FF_06FF);
        chk("t3_rf_rdb", doutb_rf, 32'h00FF_06FF);

        // T4: write modes with prior douta = 0x1111_1111
        drive(1'b1, 4'hF, 6'd3, 32'h1111_1111, 1'b0, 6'd0);
        step();
        chk("t4_nc_hold", douta_nc, 32'h00FF_06FF);
        drive(1'b1, 4'h0, 6'd3, 32'h0, 1'b0, 6'd0);
        step();
        chk("t4_nc_prior", douta_nc, 32'h1111_1111);
        drive(1'b1, 4'hF, 6'd2, 32'hA5A5_5A5A, 1'b0, 6'd0);
        step();
        chk("t4_rf", douta_rf, 32'h0);
        chk("t4_wf", douta_wf, 32'hA5A5_5A5A);
        chk("t4_nc", douta_nc, 32'h1111_1111);

        // T5: same-address collision returns old word on port B
        drive(1'b1, 4'hF, 6'd5, 32'h1234_5678, 1'b1, 6'd5);
        step();
        chk("t5_b_coll", doutb_rf, 32'h0);
        drive(1'b1, 4'h0, 6'd3, 32'h0, 1'b1, 6'd5);
        step();
        chk("t5_b_new", doutb_rf, 32'h1234_5678);
        chk("t5_or_coll", doutb_or, 32'h0);
        drive(1'b0, 4'hF, 6'd2, 32'hDEAD_0000, 1'b1, 6'd5);
        step();
        chk("t5_or_new", doutb_or, 32'h1234_5678);
        chk("t5_ena0_hold", douta_rf, 32'h1111_1111);
        chk("t5_or_a_lat2", douta_or, 32'h1111_1111);
        drive(1'b1, 4'h0, 6'd2, 32'h0, 1'b0, 6'd7);
        step();
        chk("t5_ena0_nowr", douta_rf, 32'hA5A5_5A5A);
        chk("t5_enb0_hold", doutb_rf, 32'h1234_5678);

        // T6: clear request, reset mid-clear at cnt=20, restart from 0
        drive(1'b1, 4'hF, 6'd20, 32'hDEAD_BEEF, 1'b0, 6'd0);
        step();
        drive(1'b1, 4'hF, 6'd30, 32'hCAFE_F00D, 1'b1, 6'd20);
        step();
        drive(1'b1, 4'h0, 6'd30, 32'h0, 1'b1, 6'd20);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("t6_busy_on", {31'b0, busy_rf}, 32'h1);
        chk("t6_force_a", douta_rf, 32'h0);
        chk("t6_force_b", doutb_rf, 32'h0);
        for (int i = 0; i < 20; i++) step();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_a", douta_rf, 32'h0);
        chk("t6_rst_b", doutb_or, 32'h0);
        chk("t6_rst_busy", {31'b0, busy_rf}, 32'h1);
        step();
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0);
        wait_clear("t6_busy_edges");
        drive(1'b1, 4'h0, 6'd20, 32'h0, 1'b1, 6'd30);
        step();
        chk("t6_a20", douta_rf, 32'h0);
        chk("t6_b30", doutb_rf, 32'h0);
        step();
        chk("t6_or_a20", douta_or, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
